// File: rtl/prf_pkg.sv
// Shared types and address helpers for the banked physical register file.
//   prf_state_t : sequencer state (CLEAR sweep / READY for traffic)
//   bank_of()   : bank select taken from the address MSBs
//   row_of()    : row within a bank taken from the remaining LSBs
package prf_pkg;

  typedef enum logic {
    PRF_CLEAR = 1'b0,
    PRF_READY = 1'b1
  } prf_state_t;

  // Default geometry: 128 entries split across two banks.
  localparam int unsigned PRF_DEPTH = 128;
  localparam int unsigned PRF_INDEX = 7;
  localparam int unsigned BANK_BITS = 1;
  localparam int unsigned ROWS      = PRF_DEPTH >> BANK_BITS;

  // Bank index = top bank_bits of an index-bit address (0 when unbanked).
  function automatic int unsigned bank_of(input int unsigned addr,
                                          input int unsigned index,
                                          input int unsigned bank_bits);
    int unsigned mask;
    mask = (32'd1 << bank_bits) - 32'd1;
    return (addr >> (index - bank_bits)) & mask;
  endfunction

  // Row index = address with the bank bits stripped off.
  function automatic int unsigned row_of(input int unsigned addr,
                                         input int unsigned index,
                                         input int unsigned bank_bits);
    return addr & ((32'd1 << (index - bank_bits)) - 32'd1);
  endfunction

endpackage

// File: rtl/prf_bank.sv
// One register-file bank: N_ROWS x WIDTH storage.
//   wr_en/wr_row/wr_data : NUM_WR write ports, already masked to this bank;
//                          the highest port index wins on a row collision
//   rd_row/rd_data_c     : NUM_RD asynchronous read ports
//   clr_en/clr_row       : zero one row; takes precedence over the write ports
module prf_bank
  import prf_pkg::*;
#(
  parameter int unsigned N_ROWS = ROWS,
  parameter int unsigned ROW_W  = $clog2(N_ROWS),
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned NUM_RD = 12,
  parameter int unsigned NUM_WR = 6
) (
  input  logic                    clk,
  input  logic [NUM_WR-1:0]       wr_en,
  input  logic [NUM_WR*ROW_W-1:0] wr_row,
  input  logic [NUM_WR*WIDTH-1:0] wr_data,
  input  logic [NUM_RD*ROW_W-1:0] rd_row,
  output logic [NUM_RD*WIDTH-1:0] rd_data_c,
  input  logic                    clr_en,
  input  logic [ROW_W-1:0]        clr_row
);

  logic [WIDTH-1:0] mem [N_ROWS];

  // Storage update; later loop iterations override earlier ones, so the
  // highest-index write port wins.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_row] <= '0;
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_en[w]) begin
          mem[wr_row[w*ROW_W +: ROW_W]] <= wr_data[w*WIDTH +: WIDTH];
        end
      end
    end
  end

  // Combinational read ports.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    assign rd_data_c[p*WIDTH +: WIDTH] = mem[rd_row[p*ROW_W +: ROW_W]];
  end

endmodule

// File: rtl/prf_banked_rw.sv
// Banked physical register file with registered reads, write-first bypass,
// optional hardwired zero entry and a clear sequencer that zeroes every entry
// after reset or on demand.
//   clk, reset   : clock / asynchronous active-low reset
//   clear_i      : restart the clear sweep (honoured in READY only)
//   rd_en_i      : per-port read request;  rd_addr_i : port p at [p*INDEX +: INDEX]
//   wr_en_i      : per-port write enable;  wr_addr_i / wr_data_i : per-port slices
//   data_o       : registered read data, lane holds when not read
//   rd_valid_o   : registered lane valid
//   ready_o      : 1 while the array accepts traffic
module prf_banked_rw
  import prf_pkg::*;
#(
  parameter int unsigned DEPTH     = PRF_DEPTH,
  parameter int unsigned INDEX     = PRF_INDEX,
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned NUM_BANKS = 32'd1 << BANK_BITS,
  parameter int unsigned NUM_RD    = 12,
  parameter int unsigned NUM_WR    = 6,
  parameter int unsigned ZERO_REG  = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear_i,
  input  logic [NUM_RD-1:0]       rd_en_i,
  input  logic [NUM_RD*INDEX-1:0] rd_addr_i,
  input  logic [NUM_WR-1:0]       wr_en_i,
  input  logic [NUM_WR*INDEX-1:0] wr_addr_i,
  input  logic [NUM_WR*WIDTH-1:0] wr_data_i,
  output logic [NUM_RD*WIDTH-1:0] data_o,
  output logic [NUM_RD-1:0]       rd_valid_o,
  output logic                    ready_o
);

  localparam int unsigned N_BANK_BITS = $clog2(NUM_BANKS);
  localparam int unsigned N_ROWS      = DEPTH / NUM_BANKS;
  localparam int unsigned ROW_W       = INDEX - N_BANK_BITS;
  localparam int unsigned SEL_W       = (N_BANK_BITS == 0) ? 1 : N_BANK_BITS;

  // Geometry sanity checks.
  if (DEPTH != (32'd1 << INDEX)) begin : g_chk_depth
    $error("prf_banked_rw: DEPTH must equal 2**INDEX");
  end
  if ((NUM_BANKS == 0) || ((NUM_BANKS & (NUM_BANKS - 1)) != 0)) begin : g_chk_banks
    $error("prf_banked_rw: NUM_BANKS must be a power of two");
  end
  if (NUM_BANKS > DEPTH / 2) begin : g_chk_bank_max
    $error("prf_banked_rw: NUM_BANKS must not exceed DEPTH/2");
  end

  prf_state_t       state_q, state_d;
  logic [ROW_W-1:0] clr_row_q, clr_row_d;
  logic             clr_en_c;
  logic             accept_c;

  // Sequencer state, sweep counter and ready flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= PRF_CLEAR;
      clr_row_q <= '0;
      ready_o   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_row_q <= clr_row_d;
      ready_o   <= (state_d == PRF_READY);
    end
  end

  // Next state: sweep one row per cycle in CLEAR, restart the sweep on clear_i.
  always_comb begin
    state_d   = state_q;
    clr_row_d = clr_row_q;
    clr_en_c  = 1'b0;
    accept_c  = 1'b0;
    case (state_q)
      PRF_CLEAR: begin
        clr_en_c  = 1'b1;
        clr_row_d = clr_row_q + ROW_W'(1);
        if (clr_row_q == ROW_W'(N_ROWS - 1)) begin
          state_d   = PRF_READY;
          clr_row_d = '0;
        end
      end
      PRF_READY: begin
        if (clear_i) begin
          state_d   = PRF_CLEAR;
          clr_row_d = '0;
        end else begin
          accept_c = 1'b1;
        end
      end
      default: state_d = PRF_CLEAR;
    endcase
  end

  logic [INDEX-1:0]        rd_addr [NUM_RD];
  logic [SEL_W-1:0]        rd_bank [NUM_RD];
  logic [NUM_RD*ROW_W-1:0] rd_row_flat;
  logic [INDEX-1:0]        wr_addr [NUM_WR];
  logic [WIDTH-1:0]        wr_data [NUM_WR];
  logic [SEL_W-1:0]        wr_bank [NUM_WR];
  logic [NUM_WR*ROW_W-1:0] wr_row_flat;
  logic [NUM_WR-1:0]       wr_act_c;
  logic [NUM_RD-1:0]       rd_act_c;

  // Split read addresses into bank select and row.
  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_addr
    assign rd_addr[p] = rd_addr_i[p*INDEX +: INDEX];
    assign rd_bank[p] = SEL_W'(bank_of(32'(rd_addr[p]), INDEX, N_BANK_BITS));
    assign rd_row_flat[p*ROW_W +: ROW_W] =
      ROW_W'(row_of(32'(rd_addr[p]), INDEX, N_BANK_BITS));
  end

  // Split write addresses; a write to entry 0 is dropped when it is hardwired.
  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr_addr
    assign wr_addr[w] = wr_addr_i[w*INDEX +: INDEX];
    assign wr_data[w] = wr_data_i[w*WIDTH +: WIDTH];
    assign wr_bank[w] = SEL_W'(bank_of(32'(wr_addr[w]), INDEX, N_BANK_BITS));
    assign wr_row_flat[w*ROW_W +: ROW_W] =
      ROW_W'(row_of(32'(wr_addr[w]), INDEX, N_BANK_BITS));
    assign wr_act_c[w] = wr_en_i[w] && accept_c &&
                         !((ZERO_REG != 0) && (wr_addr[w] == '0));
  end

  assign rd_act_c = rd_en_i & {NUM_RD{accept_c}};

  logic [NUM_RD*WIDTH-1:0] bank_rd_data [NUM_BANKS];

  // Banks; each sees only the writes that select it.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic [NUM_WR-1:0] bank_wr_en;
    for (genvar w = 0; w < NUM_WR; w++) begin : g_wsel
      assign bank_wr_en[w] = wr_act_c[w] && (wr_bank[w] == SEL_W'(b));
    end
    prf_bank #(
      .N_ROWS (N_ROWS),
      .ROW_W  (ROW_W),
      .WIDTH  (WIDTH),
      .NUM_RD (NUM_RD),
      .NUM_WR (NUM_WR)
    ) u_bank (
      .clk       (clk),
      .wr_en     (bank_wr_en),
      .wr_row    (wr_row_flat),
      .wr_data   (wr_data_i),
      .rd_row    (rd_row_flat),
      .rd_data_c (bank_rd_data[b]),
      .clr_en    (clr_en_c),
      .clr_row   (clr_row_q)
    );
  end

  logic [WIDTH-1:0] rd_val_c [NUM_RD];

  // Read value: bank mux, then same-cycle write bypass (highest port last),
  // then the hardwired zero entry.
  always_comb begin
    for (int p = 0; p < NUM_RD; p++) begin
      rd_val_c[p] = bank_rd_data[rd_bank[p]][p*WIDTH +: WIDTH];
      for (int w = 0; w < NUM_WR; w++) begin
        if (wr_act_c[w] && (wr_addr[w] == rd_addr[p])) begin
          rd_val_c[p] = wr_data[w];
        end
      end
      if ((ZERO_REG != 0) && (rd_addr[p] == '0)) begin
        rd_val_c[p] = '0;
      end
    end
  end

  // Output registers; an idle lane keeps its last data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_o     <= '0;
      rd_valid_o <= '0;
    end else begin
      rd_valid_o <= rd_act_c;
      for (int p = 0; p < NUM_RD; p++) begin
        if (rd_act_c[p]) begin
          data_o[p*WIDTH +: WIDTH] <= rd_val_c[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_prf_banked_rw.sv
// Bench for prf_banked_rw: two instances (ZERO_REG=0 and ZERO_REG=1) share
// stimulus and are checked every cycle against a flat-memory reference model,
// plus table-driven write/read vectors and hand-written corner sequences.
module tb_prf_banked_rw;

  localparam int unsigned INDEX  = 7;
  localparam int unsigned WIDTH  = 32;
  localparam int unsigned NUM_RD = 12;
  localparam int unsigned NUM_WR = 6;
  localparam int unsigned DEPTH  = 128;
  localparam int unsigned ROWS   = 64;
  localparam int unsigned DW     = NUM_RD * WIDTH;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic [NUM_RD-1:0] rd_en;
  logic [INDEX-1:0]  ra [NUM_RD];
  logic [NUM_WR-1:0] wr_en;
  logic [INDEX-1:0]  wa [NUM_WR];
  logic [WIDTH-1:0]  wd [NUM_WR];

  logic [NUM_RD*INDEX-1:0] rd_addr_flat;
  logic [NUM_WR*INDEX-1:0] wr_addr_flat;
  logic [NUM_WR*WIDTH-1:0] wr_data_flat;
  logic [DW-1:0]     data0, dataz;
  logic [NUM_RD-1:0] valid0, validz;
  logic              ready0, readyz;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_pr
    assign rd_addr_flat[p*INDEX +: INDEX] = ra[p];
  end
  for (genvar w = 0; w < NUM_WR; w++) begin : g_pw
    assign wr_addr_flat[w*INDEX +: INDEX] = wa[w];
    assign wr_data_flat[w*WIDTH +: WIDTH] = wd[w];
  end

  always #5 clk = ~clk;

  prf_banked_rw #(.ZERO_REG(0)) dut (
    .clk(clk), .reset(reset), .clear_i(clear),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr_flat),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr_flat), .wr_data_i(wr_data_flat),
    .data_o(data0), .rd_valid_o(valid0), .ready_o(ready0)
  );

  prf_banked_rw #(.ZERO_REG(1)) dut_z (
    .clk(clk), .reset(reset), .clear_i(clear),
    .rd_en_i(rd_en), .rd_addr_i(rd_addr_flat),
    .wr_en_i(wr_en), .wr_addr_i(wr_addr_flat), .wr_data_i(wr_data_flat),
    .data_o(dataz), .rd_valid_o(validz), .ready_o(readyz)
  );

  // Reference model: index 0 = plain instance, index 1 = zero-register instance.
  logic [WIDTH-1:0]  mem [2][DEPTH];
  logic [WIDTH-1:0]  exp_data [2][NUM_RD];
  logic [NUM_RD-1:0] exp_valid;
  int                sweep_left;
  bit                in_reset;
  int                n_checks = 0;
  int                n_pass   = 0;

  typedef struct {
    logic [INDEX-1:0] waddr;
    logic [WIDTH-1:0] wdata;
    int               wport;
    logic [INDEX-1:0] raddr;
    int               rport;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] pack_exp(input int m);
    logic [DW-1:0] r;
    for (int p = 0; p < NUM_RD; p++) r[p*WIDTH +: WIDTH] = exp_data[m][p];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] model_read(input int m, input logic [INDEX-1:0] a);
    logic [WIDTH-1:0] v;
    if (m == 1 && a == '0) return '0;
    v = mem[m][a];
    for (int w = 0; w < NUM_WR; w++)
      if (wr_en[w] && wa[w] == a) v = wd[w];
    return v;
  endfunction

  task automatic model_zero();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < DEPTH; i++) mem[m][i] = '0;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_step();
    if (in_reset) return;
    if (sweep_left > 0) begin
      sweep_left--;
      exp_valid = '0;
    end else if (clear) begin
      sweep_left = ROWS;
      exp_valid  = '0;
      model_zero();
    end else begin
      for (int m = 0; m < 2; m++)
        for (int p = 0; p < NUM_RD; p++)
          if (rd_en[p]) exp_data[m][p] = model_read(m, ra[p]);
      for (int m = 0; m < 2; m++)
        for (int w = 0; w < NUM_WR; w++)
          if (wr_en[w] && !(m == 1 && wa[w] == '0)) mem[m][wa[w]] = wd[w];
      exp_valid = rd_en;
    end
  endtask

  task automatic check_outputs();
    check("ready",   DW'(ready0), DW'((sweep_left == 0) && !in_reset));
    check("ready_z", DW'(readyz), DW'((sweep_left == 0) && !in_reset));
    check("valid",   DW'(valid0), DW'(exp_valid));
    check("valid_z", DW'(validz), DW'(exp_valid));
    check("data",    data0, pack_exp(0));
    check("data_z",  dataz, pack_exp(1));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle();
    rd_en = '0;
    wr_en = '0;
    clear = 1'b0;
    for (int p = 0; p < NUM_RD; p++) ra[p] = '0;
    for (int w = 0; w < NUM_WR; w++) begin
      wa[w] = '0;
      wd[w] = '0;
    end
  endtask

  task automatic apply_reset();
    reset      = 1'b0;
    in_reset   = 1'b1;
    sweep_left = ROWS;
    exp_valid  = '0;
    for (int m = 0; m < 2; m++)
      for (int p = 0; p < NUM_RD; p++) exp_data[m][p] = '0;
    model_zero();
    #1;
    check_outputs();
    repeat (2) cycle();
    @(negedge clk);
    reset    = 1'b1;
    in_reset = 1'b0;
  endtask

  task automatic wait_ready(input int exp_n);
    int n;
    n = 0;
    while (n < 200) begin
      cycle();
      n++;
      if (ready0) break;
    end
    check("ready_latency", DW'(n), DW'(exp_n));
  endtask

  task automatic read_all_zero(input string name);
    for (int base = 0; base < DEPTH; base += NUM_RD) begin
      idle();
      rd_en = '1;
      for (int p = 0; p < NUM_RD; p++) ra[p] = INDEX'((base + p) % DEPTH);
      cycle();
      check(name, data0, '0);
    end
    idle();
  endtask

  function automatic logic [INDEX-1:0] pick_addr();
    case ($urandom_range(0, 3))
      0:       return INDEX'($urandom_range(0, 3));
      1:       return INDEX'($urandom_range(63, 66));
      default: return INDEX'($urandom_range(0, DEPTH - 1));
    endcase
  endfunction

  initial begin
    reset = 1'b0;
    idle();

    vecs[0] = '{7'h05, 32'hDEAD_BEEF, 0, 7'h05, 3,  32'hDEAD_BEEF};
    vecs[1] = '{7'h3F, 32'h0000_000A, 2, 7'h3F, 10, 32'h0000_000A};
    vecs[2] = '{7'h40, 32'h0000_000B, 5, 7'h40, 11, 32'h0000_000B};
    vecs[3] = '{7'h7F, 32'h1234_5678, 3, 7'h7F, 6,  32'h1234_5678};
    vecs[4] = '{7'h00, 32'hCAFE_F00D, 1, 7'h00, 7,  32'hCAFE_F00D};
    vecs[5] = '{7'h41, 32'h0000_0077, 4, 7'h01, 8,  32'h0000_0000};

    // Reset, sweep length and all-zero contents.
    apply_reset();
    wait_ready(ROWS);
    read_all_zero("post_reset_zero");

    // Table: write on one cycle, read back on the next.
    foreach (vecs[i]) begin
      idle();
      wr_en[vecs[i].wport] = 1'b1;
      wa[vecs[i].wport]    = vecs[i].waddr;
      wd[vecs[i].wport]    = vecs[i].wdata;
      cycle();
      idle();
      rd_en[vecs[i].rport] = 1'b1;
      ra[vecs[i].rport]    = vecs[i].raddr;
      cycle();
      check("vec_data",  DW'(data0[vecs[i].rport*WIDTH +: WIDTH]), DW'(vecs[i].exp));
      check("vec_valid", DW'(valid0[vecs[i].rport]), DW'(1'b1));
    end

    // Bank boundary read on two ports at once.
    idle();
    rd_en[10] = 1'b1; ra[10] = 7'h3F;
    rd_en[11] = 1'b1; ra[11] = 7'h40;
    cycle();
    check("boundary_3f", DW'(data0[10*WIDTH +: WIDTH]), DW'(32'h0000_000A));
    check("boundary_40", DW'(data0[11*WIDTH +: WIDTH]), DW'(32'h0000_000B));

    // Idle lane holds its data with valid low.
    idle();
    cycle();
    check("hold_lane3",  DW'(data0[3*WIDTH +: WIDTH]), DW'(32'hDEAD_BEEF));
    check("hold_valid3", DW'(valid0[3]), DW'(1'b0));

    // Same-cycle write collision with bypass; highest port wins.
    idle();
    wr_en[1] = 1'b1; wa[1] = 7'h70; wd[1] = 32'h11;
    wr_en[4] = 1'b1; wa[4] = 7'h70; wd[4] = 32'h44;
    rd_en[0] = 1'b1; ra[0] = 7'h70;
    cycle();
    check("bypass_prio", DW'(data0[WIDTH-1:0]), DW'(32'h44));
    idle();
    rd_en[0] = 1'b1; ra[0] = 7'h70;
    cycle();
    check("stored_prio", DW'(data0[WIDTH-1:0]), DW'(32'h44));

    // Hardwired zero register: bypass and stored reads of address 0.
    idle();
    wr_en[0] = 1'b1; wa[0] = 7'h00; wd[0] = 32'h55;
    rd_en[0] = 1'b1; ra[0] = 7'h00;
    cycle();
    check("zero_bypass",   DW'(dataz[WIDTH-1:0]), DW'(32'h0));
    check("plain_bypass0", DW'(data0[WIDTH-1:0]), DW'(32'h55));
    idle();
    rd_en[0] = 1'b1; ra[0] = 7'h00;
    cycle();
    check("zero_stored",   DW'(dataz[WIDTH-1:0]), DW'(32'h0));
    check("plain_stored0", DW'(data0[WIDTH-1:0]), DW'(32'h55));

    // clear_i in READY drops that cycle's read, then reset mid-sweep.
    idle();
    clear    = 1'b1;
    rd_en[2] = 1'b1; ra[2] = 7'h05;
    wr_en[2] = 1'b1; wa[2] = 7'h06; wd[2] = 32'h99;
    cycle();
    check("clear_valid", DW'(valid0), DW'(0));
    idle();
    for (int c = 0; c < 10; c++) begin
      rd_en = NUM_RD'($urandom);
      wr_en = NUM_WR'($urandom);
      for (int p = 0; p < NUM_RD; p++) ra[p] = pick_addr();
      for (int w = 0; w < NUM_WR; w++) begin
        wa[w] = pick_addr();
        wd[w] = $urandom;
      end
      cycle();
    end
    idle();
    apply_reset();
    wait_ready(ROWS);
    read_all_zero("post_clear_zero");

    // Randomised traffic with occasional clears.
    for (int c = 0; c < 400; c++) begin
      clear = ($urandom_range(0, 149) == 0);
      rd_en = NUM_RD'($urandom);
      wr_en = NUM_WR'($urandom);
      for (int p = 0; p < NUM_RD; p++) ra[p] = pick_addr();
      for (int w = 0; w < NUM_WR; w++) begin
        wa[w] = pick_addr();
        wd[w] = $urandom;
      end
      cycle();
    end
    idle();
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1, "timeout");
  end

endmodule
